// File: rtl/sdspi_cmd_sequencer_if.sv
// Bundle of the command-request side and the spi_master side of the
// SD-SPI command sequencer. The sequencer uses the slave modport; the
// requester/environment (autotest FSM plus spi_master) uses master.
interface sdspi_cmd_sequencer_if;
  // Command / configuration request side
  logic        cfg_start;
  logic [7:0]  clk_div;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy;
  logic        done;
  logic [7:0]  resp_r1;
  logic        timeout;
  // spi_master side
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out;
  logic        spi_w_data;
  logic        spi_w_conf;
  logic        spi_ss;
  logic        spi_busy;

  modport slave (
    input  cfg_start, clk_div, cmd_start, cmd_index, cmd_arg, cmd_crc,
    input  spi_data_out, spi_busy,
    output busy, done, resp_r1, timeout,
    output spi_data_in, spi_w_data, spi_w_conf, spi_ss
  );

  modport master (
    output cfg_start, clk_div, cmd_start, cmd_index, cmd_arg, cmd_crc,
    output spi_data_out, spi_busy,
    input  busy, done, resp_r1, timeout,
    input  spi_data_in, spi_w_data, spi_w_conf, spi_ss
  );
endinterface

// File: rtl/sdspi_cmd_sequencer.sv
// SD-SPI command sequencer: loads the SCLK divider into spi_master, or
// frames one SD command (sync byte + 6 command bytes) under a continuous
// chip select and polls with 0xFF until an R1 byte or a timeout.
module sdspi_cmd_sequencer #(
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input logic                  clk,
  input logic                  rst,
  sdspi_cmd_sequencer_if.slave bus
);

  localparam logic [7:0] LP_TIMEOUT = 8'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_LOAD, S_GUARD, S_WAIT, S_NEXT, S_CHECK, S_FIN
  } state_t;

  state_t      r_state;
  logic [5:0]  r_index;
  logic [31:0] r_arg;
  logic [6:0]  r_crc;
  logic [2:0]  r_byte_idx;   // 0..6 command bytes, 7 = poll phase
  logic [7:0]  r_poll_cnt;
  logic [1:0]  r_guard;
  logic        r_busy;
  logic        r_done;
  logic        r_timeout;
  logic        r_w_data;
  logic        r_w_conf;
  logic        r_ss;
  logic [7:0]  r_resp_r1;
  logic [7:0]  r_data_in;

  logic [7:0]  w_cur_byte;
  logic [7:0]  w_poll_next;
  logic        w_poll_phase;

  // Byte currently being framed; index 7 (poll phase) sends 0xFF.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_cur_byte unassigned (no latch).
    w_cur_byte = 8'hFF;
    case (r_byte_idx)
      3'd0:    w_cur_byte = 8'hFF;
      3'd1:    w_cur_byte = {2'b01, r_index};
      3'd2:    w_cur_byte = r_arg[31:24];
      3'd3:    w_cur_byte = r_arg[23:16];
      3'd4:    w_cur_byte = r_arg[15:8];
      3'd5:    w_cur_byte = r_arg[7:0];
      3'd6:    w_cur_byte = {r_crc, 1'b1};
      default: w_cur_byte = 8'hFF;
    endcase
  end

  assign w_poll_phase = (r_byte_idx == 3'd7);
  // Poll counter saturates instead of wrapping.
  assign w_poll_next  = (r_poll_cnt == 8'hFF) ? r_poll_cnt : r_poll_cnt + 8'd1;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is non-blocking (<=) so all updates land together at the edge.
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_arg      <= '0;
      r_crc      <= '0;
      r_byte_idx <= '0;
      r_poll_cnt <= '0;
      r_guard    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_w_data   <= 1'b0;
      r_w_conf   <= 1'b0;
      r_ss       <= 1'b1;
      r_resp_r1  <= 8'hFF;
      r_data_in  <= 8'hFF;
    end else begin
      // Strobes and done are single-cycle unless re-asserted below.
      r_w_data <= 1'b0;
      r_w_conf <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy is still high during the done cycle; requests then are ignored.
          r_busy <= 1'b0;
          if (!r_busy) begin
            if (bus.cfg_start) begin
              r_busy  <= 1'b1;
              r_state <= S_CONF;
            end else if (bus.cmd_start) begin
              r_index    <= bus.cmd_index;
              r_arg      <= bus.cmd_arg;
              r_crc      <= bus.cmd_crc;
              r_byte_idx <= '0;
              r_poll_cnt <= '0;
              r_timeout  <= 1'b0;
              r_resp_r1  <= 8'hFF;
              r_ss       <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_CONF: begin
          r_data_in <= bus.clk_div;
          r_w_conf  <= 1'b1;
          r_state   <= S_FIN;
        end
        S_LOAD: begin
          r_data_in <= w_cur_byte;
          r_w_data  <= 1'b1;
          r_guard   <= 2'd2;
          r_state   <= S_GUARD;
        end
        S_GUARD: begin
          // spi_master raises busy two cycles after the strobe.
          r_guard <= r_guard - 2'd1;
          if (r_guard == 2'd1) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.spi_busy) r_state <= w_poll_phase ? S_CHECK : S_NEXT;
        end
        S_NEXT: begin
          r_byte_idx <= r_byte_idx + 3'd1;
          r_state    <= S_LOAD;
        end
        S_CHECK: begin
          r_poll_cnt <= w_poll_next;
          if (!bus.spi_data_out[7]) begin
            r_resp_r1 <= bus.spi_data_out;
            r_state   <= S_FIN;
          end else if (w_poll_next == LP_TIMEOUT) begin
            r_timeout <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_FIN: begin
          r_ss    <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.resp_r1     = r_resp_r1;
  assign bus.timeout     = r_timeout;
  assign bus.spi_data_in = r_data_in;
  assign bus.spi_w_data  = r_w_data;
  assign bus.spi_w_conf  = r_w_conf;
  assign bus.spi_ss      = r_ss;

endmodule

// File: tb/tb_sdspi_cmd_sequencer.sv
// Directed bench for sdspi_cmd_sequencer with a behavioural spi_master
// slave model that answers poll bytes from a response queue.
module tb_sdspi_cmd_sequencer;

  logic clk;
  logic rst;

  sdspi_cmd_sequencer_if bus ();

  sdspi_cmd_sequencer #(.RESP_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] sent[$];
  logic [7:0] resp_q[$];
  logic [7:0] exp_q[$];
  int         phase        = 0;
  int         done_cnt     = 0;
  int         conf_cnt     = 0;
  int         both_cnt     = 0;
  int         ss_hi_strobe = 0;
  logic [7:0] conf_val     = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // spi_master model: busy rises 2 cycles after the strobe, stays 3 cycles,
  // then the received byte (from resp_q for poll bytes, else 0xFF) is held.
  always @(negedge clk) begin
    if (rst) begin
      phase            = 0;
      bus.spi_busy     = 1'b0;
      bus.spi_data_out = 8'hFF;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.spi_w_conf) begin
        conf_cnt++;
        conf_val = bus.spi_data_in;
      end
      if (bus.spi_w_data && bus.spi_w_conf) both_cnt++;
      if (bus.spi_w_data) begin
        sent.push_back(bus.spi_data_in);
        if (bus.spi_ss) ss_hi_strobe++;
        phase = 1;
      end else if (phase != 0) begin
        phase++;
        if (phase == 2) bus.spi_busy = 1'b1;
        if (phase == 5) begin
          bus.spi_busy = 1'b0;
          if (sent.size() > 7 && resp_q.size() > 0) bus.spi_data_out = resp_q.pop_front();
          else                                      bus.spi_data_out = 8'hFF;
          phase = 0;
        end
      end
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input bit disturb);
    int n;
    int d0;
    sent.delete();
    d0 = done_cnt;
    @(negedge clk);
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.cmd_crc   = crc;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.cmd_index = ~idx;
    bus.cmd_arg   = ~arg;
    bus.cmd_crc   = ~crc;
    check("accept_busy", bus.busy, 1);
    check("accept_ss", bus.spi_ss, 0);
    n = 0;
    while (!bus.done && n < 3000) begin
      @(negedge clk);
      n++;
      if (disturb && n == 10) begin
        bus.cmd_start = 1'b1;
        bus.cfg_start = 1'b1;
        bus.cmd_index = 6'h15;
        bus.cmd_arg   = 32'hDEADBEEF;
      end
      if (disturb && n == 11) begin
        bus.cmd_start = 1'b0;
        bus.cfg_start = 1'b0;
      end
    end
    check("done_seen", bus.done, 1);
    check("done_busy", bus.busy, 1);
    @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_ss", bus.spi_ss, 1);
  endtask

  task automatic check_bytes();
    check("n_bytes", sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      check($sformatf("byte%0d", i), sent[i], exp_q[i]);
  endtask

  initial begin
    int k;
    int d0;
    int c0;
    rst           = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cmd_start = 1'b0;
    bus.clk_div   = 8'h00;
    bus.cmd_index = 6'h00;
    bus.cmd_arg   = 32'h0;
    bus.cmd_crc   = 7'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_resp", bus.resp_r1, 8'hFF);
    check("rst_timeout", bus.timeout, 0);
    check("rst_data_in", bus.spi_data_in, 8'hFF);
    check("rst_w_data", bus.spi_w_data, 0);
    check("rst_w_conf", bus.spi_w_conf, 0);
    check("rst_ss", bus.spi_ss, 1);
    rst = 1'b0;
    @(negedge clk);

    // Configuration load
    bus.clk_div   = 8'h02;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    check("cfg_busy", bus.busy, 1);
    check("cfg_ss0", bus.spi_ss, 1);
    @(negedge clk);
    check("cfg_w_conf", bus.spi_w_conf, 1);
    check("cfg_w_data", bus.spi_w_data, 0);
    check("cfg_data", bus.spi_data_in, 8'h02);
    check("cfg_done_early", bus.done, 0);
    @(negedge clk);
    check("cfg_done", bus.done, 1);
    check("cfg_w_conf_off", bus.spi_w_conf, 0);
    check("cfg_ss1", bus.spi_ss, 1);
    @(negedge clk);
    check("cfg_done_off", bus.done, 0);
    check("cfg_idle_busy", bus.busy, 0);
    check("cfg_count", conf_cnt, 1);

    // CMD0: R1 arrives on the second poll byte
    resp_q = '{8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
    exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF};
    check_bytes();
    check("cmd0_resp", bus.resp_r1, 8'h01);
    check("cmd0_timeout", bus.timeout, 0);
    @(negedge clk);
    check("cmd0_resp_hold", bus.resp_r1, 8'h01);

    // CMD8 with requests pulsed while busy: they must be ignored
    resp_q = '{8'h01};
    run_cmd(6'd8, 32'h000001AA, 7'h43, 1'b1);
    exp_q = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF};
    check_bytes();
    check("cmd8_resp", bus.resp_r1, 8'h01);
    check("cmd8_no_cfg", conf_cnt, 1);
    repeat (3) @(negedge clk);
    check("cmd8_no_restart", bus.busy, 0);

    // Timeout: MISO stays high for all 8 poll bytes
    resp_q.delete();
    run_cmd(6'd17, 32'h00001234, 7'h11, 1'b0);
    check("to_n_bytes", sent.size(), 15);
    if (sent.size() >= 15) begin
      check("to_b1", sent[1], 8'h51);
      check("to_b6", sent[6], 8'h23);
      for (int i = 7; i < 15; i++) check($sformatf("to_poll%0d", i - 7), sent[i], 8'hFF);
    end
    check("to_timeout", bus.timeout, 1);
    check("to_resp", bus.resp_r1, 8'hFF);

    // cfg_start and cmd_start together: only the config runs
    sent.delete();
    d0 = done_cnt;
    c0 = conf_cnt;
    @(negedge clk);
    bus.clk_div   = 8'h07;
    bus.cfg_start = 1'b1;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.cmd_start = 1'b0;
    repeat (5) @(negedge clk);
    check("both_no_bytes", sent.size(), 0);
    check("both_cfg_count", conf_cnt - c0, 1);
    check("both_cfg_val", conf_val, 8'h07);
    check("both_done", done_cnt - d0, 1);
    check("both_ss", bus.spi_ss, 1);
    check("both_timeout_kept", bus.timeout, 1);

    // Reset during the 3rd command byte
    resp_q = '{8'h01};
    sent.delete();
    @(negedge clk);
    bus.cmd_index = 6'd0;
    bus.cmd_arg   = 32'h0;
    bus.cmd_crc   = 7'h4A;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    k = 0;
    for (int i = 0; i < 500 && k < 3; i++) begin
      @(negedge clk);
      if (bus.spi_w_data) k++;
    end
    check("rst_reached_b3", k, 3);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_ss", bus.spi_ss, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_resp", bus.resp_r1, 8'hFF);
    check("mid_rst_w_data", bus.spi_w_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    resp_q = '{8'h01};
    run_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
    exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF};
    check_bytes();
    check("post_rst_resp", bus.resp_r1, 8'h01);
    check("post_rst_timeout", bus.timeout, 0);

    check("no_dual_strobe", both_cnt, 0);
    check("ss_low_on_strobes", ss_hi_strobe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
